// File: rtl/powlib_ramrd.sv
// Burst reader for a dual-port RAM read port: turns {index, length} commands into
// a stream of beats, wrapping the index at depth D, with a one-entry output register.

package powlib_pkg;
  // Ceiling log2 with a floor of 1, so that a depth of 1 still gets a usable index.
  function automatic int powlib_clogb2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction
endpackage

module powlib_ramrd
  import powlib_pkg::*;
#(
  parameter int W    = 16,
  parameter int D    = 8,
  parameter int WIDX = powlib_clogb2(D),
  parameter int WLEN = WIDX + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WIDX-1:0] cmdidx,
  input  logic [WLEN-1:0] cmdlen,
  input  logic            cmdvld,
  output logic            cmdrdy,
  output logic [WIDX-1:0] rdidx,
  input  logic [W-1:0]    rddata,
  output logic [W-1:0]    outdata,
  output logic            outvld,
  input  logic            outrdy,
  output logic            outlast,
  output logic            busy
);

  typedef enum logic [0:0] {IDLE, READ} state_t;

  state_t          state_q, state_d;
  logic [WIDX-1:0] ptr_q, ptr_d;
  logic [WLEN-1:0] rem_q, rem_d;
  logic [W-1:0]    outdata_q, outdata_d;
  logic            outvld_q, outvld_d;
  logic            outlast_q, outlast_d;

  // Gated by rst so the command port reads not-ready throughout reset.
  assign cmdrdy  = (state_q == IDLE) && rst;
  assign rdidx   = ptr_q;
  assign outdata = outdata_q;
  assign outvld  = outvld_q;
  assign outlast = outlast_q;
  assign busy    = (state_q == READ) || outvld_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    outdata_d = outdata_q;
    outvld_d  = outvld_q;
    outlast_d = outlast_q;
    case (state_q)
      IDLE: begin
        if (outvld_q && outrdy) begin
          outvld_d  = 1'b0;
          outlast_d = 1'b0;
        end
        // A zero-length command is consumed here without leaving IDLE.
        if (cmdvld && cmdrdy && (cmdlen != '0)) begin
          ptr_d   = cmdidx;
          rem_d   = cmdlen;
          state_d = READ;
        end
      end
      READ: begin
        if (!outvld_q || outrdy) begin
          outdata_d = rddata;
          outvld_d  = 1'b1;
          outlast_d = (rem_q == WLEN'(1));
          ptr_d     = (ptr_q == WIDX'(D - 1)) ? '0 : ptr_q + WIDX'(1);
          rem_d     = rem_q - WLEN'(1);
          if (rem_q == WLEN'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      rem_q     <= '0;
      outdata_q <= '0;
      outvld_q  <= 1'b0;
      outlast_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      outdata_q <= outdata_d;
      outvld_q  <= outvld_d;
      outlast_q <= outlast_d;
    end
  end

endmodule

// File: tb/tb_powlib_ramrd.sv
// Directed bench for powlib_ramrd: a behavioural RAM feeds rddata, a scoreboard
// queue holds expected beats, and a negedge monitor checks each handshake.

module tb_powlib_ramrd;

  localparam int W = 16;
  localparam int D = 8;
  localparam int WIDX = 3;
  localparam int WLEN = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [WIDX-1:0] cmdidx = '0;
  logic [WLEN-1:0] cmdlen = '0;
  logic            cmdvld = 1'b0;
  logic            cmdrdy;
  logic [WIDX-1:0] rdidx;
  logic [W-1:0]    rddata;
  logic [W-1:0]    outdata;
  logic            outvld;
  logic            outrdy = 1'b0;
  logic            outlast;
  logic            busy;

  logic [W-1:0] mem [D];
  beat_t        q [$];
  int           n_checks = 0;
  int           n_pass = 0;

  assign rddata = mem[rdidx];

  always #5 clk = ~clk;

  powlib_ramrd #(.W(W), .D(D), .WIDX(WIDX), .WLEN(WLEN)) dut (
    .clk(clk), .rst(rst),
    .cmdidx(cmdidx), .cmdlen(cmdlen), .cmdvld(cmdvld), .cmdrdy(cmdrdy),
    .rdidx(rdidx), .rddata(rddata),
    .outdata(outdata), .outvld(outvld), .outrdy(outrdy), .outlast(outlast),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a command, queues its expected beats, and returns just after the accepting edge.
  task automatic send_cmd(input int idx, input int len);
    int   t;
    logic rdy;
    cmdidx = WIDX'(idx);
    cmdlen = WLEN'(len);
    cmdvld = 1'b1;
    for (int k = 0; k < len; k++) begin
      q.push_back('{d: mem[(idx + k) % D], l: (k == len - 1)});
    end
    t = 0;
    do begin
      @(negedge clk);
      rdy = cmdrdy;
      tick();
      t++;
    end while (!rdy && t < 50);
    if (!rdy) check("cmd_accept_timeout", 32'(rdy), 32'd1);
    cmdvld = 1'b0;
    $display("cmd idx=%0d len=%0d accepted", idx, len);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((q.size() != 0 || busy) && t < 200) begin
      tick();
      t++;
    end
    check(tag, 32'(q.size()), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Handshake monitor: scoreboard compare, stability under stall, outlast qualification.
  logic        stall_prev = 1'b0;
  logic [17:0] hold_prev = '0;
  always @(negedge clk) begin
    beat_t exp_b;
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check("hold_stable", 32'({outvld, outlast, outdata}), 32'(hold_prev));
      if (!outvld) check("outlast_idle", 32'(outlast), 32'd0);
      if (outvld && outrdy) begin
        if (q.size() == 0) begin
          check("extra_beat", 32'(outdata), 32'hffff_ffff);
        end else begin
          exp_b = q.pop_front();
          $display("beat data=%h last=%0d (exp %h/%0d)", outdata, outlast, exp_b.d, exp_b.l);
          check("beat_data", 32'(outdata), 32'(exp_b.d));
          check("beat_last", 32'(outlast), 32'(exp_b.l));
        end
      end
      stall_prev = outvld && !outrdy;
      hold_prev  = {outvld, outlast, outdata};
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    for (int i = 0; i < D; i++) mem[i] = 16'h100 + 16'(i);

    // Reset values
    tick();
    tick();
    @(negedge clk);
    check("rst_cmdrdy", 32'(cmdrdy), 32'd0);
    check("rst_outvld", 32'(outvld), 32'd0);
    check("rst_outlast", 32'(outlast), 32'd0);
    check("rst_outdata", 32'(outdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdidx", 32'(rdidx), 32'd0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rel_cmdrdy", 32'(cmdrdy), 32'd1);
    tick();

    // Basic burst with latency checks
    outrdy = 1'b1;
    send_cmd(2, 3);
    @(negedge clk);
    check("basic_lat_vld", 32'(outvld), 32'd0);
    check("basic_lat_busy", 32'(busy), 32'd1);
    check("basic_lat_rdy", 32'(cmdrdy), 32'd0);
    tick();
    @(negedge clk);
    check("basic_first_vld", 32'(outvld), 32'd1);
    check("basic_first_data", 32'(outdata), 32'h102);
    tick();
    @(negedge clk);
    check("basic_mid_last", 32'(outlast), 32'd0);
    tick();
    @(negedge clk);
    check("basic_last_data", 32'(outdata), 32'h104);
    check("basic_last_flag", 32'(outlast), 32'd1);
    check("basic_rdy_after", 32'(cmdrdy), 32'd1);
    tick();
    drain("basic_drain");

    // Wrap past D-1
    send_cmd(6, 4);
    drain("wrap_drain");

    // Backpressure, with a RAM write to a beat already captured
    send_cmd(0, 4);
    for (int c = 0; c < 40 && (q.size() != 0 || busy); c++) begin
      outrdy = pat[c % 7] != 0;
      if (c == 2) mem[0] = 16'hdead;
      tick();
    end
    check("bp_done", 32'(q.size()), 32'd0);
    mem[0] = 16'h100;
    outrdy = 1'b1;
    tick();

    // Zero-length command
    send_cmd(3, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("zero_novld", 32'(outvld), 32'd0);
      check("zero_rdy", 32'(cmdrdy), 32'd1);
      tick();
    end

    // Oversize burst revisits entries
    send_cmd(7, 10);
    drain("over_drain");

    // Asynchronous reset during beat 2
    send_cmd(0, 5);
    tick();
    tick();
    #3;
    rst = 1'b0;
    #1;
    check("arst_outvld", 32'(outvld), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_cmdrdy", 32'(cmdrdy), 32'd0);
    q.delete();
    tick();
    tick();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("arst_nobeat", 32'(outvld), 32'd0);
      check("arst_rdy", 32'(cmdrdy), 32'd1);
      tick();
    end
    send_cmd(4, 1);
    drain("arst_single");

    // Back-to-back: B accepted while A's last beat is stalled
    send_cmd(1, 2);
    tick();
    tick();
    outrdy = 1'b0;
    send_cmd(5, 2);
    @(negedge clk);
    check("b2b_pend_data", 32'(outdata), 32'h102);
    check("b2b_pend_last", 32'(outlast), 32'd1);
    check("b2b_busy", 32'(busy), 32'd1);
    tick();
    tick();
    @(negedge clk);
    check("b2b_still_pend", 32'(outdata), 32'h102);
    tick();
    outrdy = 1'b1;
    drain("b2b_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/powlib_ramrd.md
POWLIB_RAMRD -- requirements
Module: powlib_ramrd

Interface
REQ-001 The block SHALL have the following parameters:
- W: default 16; data width.
- D: default 8; memory depth in entries.
- WIDX: default powlib_clogb2(D); index width.
- WLEN: default WIDX+1; command length width.
REQ-002 The block SHALL have the following ports:
- clk  in  1  clock; all state updates on posedge clk.
- rst  in  1  reset; asynchronous, active-low (rst==0 resets; release synchronous to clk).
- cmdidx  in  WIDX  start index of burst.
- cmdlen  in  WLEN  number of beats to read.
- cmdvld  in  1  command valid.
- cmdrdy  out  1  command ready.
- rdidx  out  WIDX  read index driven to a powlib_dpram read port (combinational read).
- rddata  in  W  read data returned combinationally for rdidx.
- outdata  out  W  output beat data.
- outvld  out  1  output beat valid.
- outrdy  in  1  output beat ready.
- outlast  out  1  marks final beat of burst.
- busy  out  1  high while a burst is active or a beat is held in the output register.

Function
REQ-003 The FSM SHALL have exactly two states, IDLE and READ.
REQ-004 cmdrdy SHALL equal 1 only in IDLE with rst==1; a command is accepted on a clk edge where cmdvld==1 and cmdrdy==1.
REQ-005 On acceptance with cmdlen!=0:
- ptr loads cmdidx.
- remaining-count loads cmdlen.
- FSM goes to READ.
REQ-006 On acceptance with cmdlen==0, the command SHALL be consumed with no beats emitted, and the FSM SHALL stay in IDLE.
REQ-007 rdidx SHALL be driven directly from the registered ptr.
REQ-008 Capture condition: in READ, when outvld==0 or outrdy==1, the next clk edge SHALL:
- load outdata<=rddata;
- set outvld<=1;
- set outlast<=(remaining==1);
- advance ptr;
- decrement remaining.
REQ-009 ptr advance SHALL wrap: D-1 -> 0 (D need not be a power of 2).
REQ-010 cmdlen>D SHALL be legal; reads wrap and revisit entries.
REQ-011 When the beat with outlast=1 is captured, the FSM SHALL return to IDLE on that same edge.
REQ-012 In IDLE, outvld SHALL clear on an edge where outvld==1 and outrdy==1.
REQ-013 Latency SHALL be as follows:
- Acceptance edge = E0.
- First beat is visible (outvld=1) after edge E0+1.
- Throughput is 1 beat/clk while outrdy==1.
- An L-beat burst completes its last handshake no earlier than edge E0+L+1.
REQ-014 Backpressure: while outvld==1 and outrdy==0, outdata, outlast and outvld SHALL hold stable, and ptr and remaining SHALL hold.
REQ-015 A new command MAY be accepted on the edge after last-beat capture, while that last beat is still pending; its first beat SHALL be captured only after the pending beat handshakes (REQ-008).
REQ-016 busy SHALL equal (state==READ) or (outvld==1).
REQ-017 outlast SHALL be 0 whenever outvld==0.
REQ-018 Data SHALL be sampled from rddata at capture time; memory writes to an index after its capture do not affect the emitted beat.

Reset
REQ-019 While rst==0, the block SHALL hold the following values:
- state: IDLE.
- ptr: 0.
- remaining: 0.
- outdata: 0.
- outvld: 0.
- outlast: 0.
- cmdrdy: 0.
- busy: 0.
- rdidx: 0.
REQ-020 Reset asserted mid-burst SHALL abort the burst immediately and asynchronously; no further beats are emitted after release.
REQ-021 cmdrdy SHALL read 1 in the first cycle after rst is released.

Verification
REQ-022 Basic burst:
- Setup: D=8, mem[i]=0x100+i, outrdy=1.
- Stimulus: cmd idx=2, len=3.
- Required response: beats 0x102, 0x103, 0x104 on consecutive cycles starting E0+1; outlast only on 0x104; cmdrdy=1 one cycle after last capture.
REQ-023 Wrap:
- Stimulus: cmd idx=6, len=4.
- Required response: beats 0x106, 0x107, 0x100, 0x101; outlast on 0x101.
REQ-024 Backpressure:
- Stimulus: idx=0, len=4; outrdy toggles 1,0,0,1,1,0,1...
- Required response: exactly 0x100..0x103 in order, each stable while stalled; no duplicates or drops.
REQ-025 Zero length and oversize:
- Stimulus: len=0.
- Required response: no outvld, cmdrdy stays 1.
- Stimulus: len=10 from idx=7.
- Required response: 10 beats 0x107, 0x100..0x107, 0x100; outlast on the 10th beat.
REQ-026 Reset mid-burst:
- Stimulus: drive rst=0 asynchronously (between edges) during beat 2 of a len=5 burst.
- Required response: outvld, busy and cmdrdy fall immediately.
- After release, a new cmd idx=4, len=1 yields a single beat 0x104 with outlast=1.
REQ-027 Back-to-back:
- Setup: outrdy=0 when the last beat of burst A is captured.
- Stimulus: present burst B command.
- Required response: B is accepted while A's last beat is pending; B's first beat appears only after A's last handshake.
